if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- pause  in  6  stall vector; pause[1] high means the if_id register holds
- clear  in  1  exception/eret flush
- clear_pc  in  32  flush target
- branch  in  1  actual branch resolved in ID
- branch_target  in  32  branch target
- tlb_hit  in  1  address-mapping hit for inst_addr
- inst_req  out  1  instruction request valid
- inst_addr  out  32  request address
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  32  read data
- if2_pc  out  32  PC delivered to if_id
- if2_inst  out  32  instruction delivered to if_id
- if_inst_found  out  1  mapping hit for the delivered instruction
- if_inst_v  out  1  address valid for the delivered instruction
- stallreq_if  out  1  fetch not ready; the stall controller holds if_id

Function
REQ-003 The FSM SHALL have states REQ (inst_req=1), WAIT (awaiting data_ok), HOLD (instruction buffered), DISCARD (drop one stale response).
REQ-004 A register pc SHALL drive inst_addr; REQ moves to WAIT on inst_addr_ok, latching tlb_hit into found_r.
REQ-005 In WAIT, inst_data_ok SHALL capture inst_rdata; with pause[1]=0 it SHALL be delivered that cycle, pc+=4 and the FSM returns to REQ; with pause[1]=1 it SHALL go to HOLD.
REQ-006 HOLD SHALL present the buffered instruction until a cycle with pause[1]=0, then pc+=4 and go to REQ.
REQ-007 Delivery SHALL drive if2_pc=pc, if2_inst=data, if_inst_found=found_r, if_inst_v=1, stallreq_if=0, combinationally from state.
REQ-008 Otherwise the outputs SHALL be a bubble: if2_pc=0, if2_inst=0, if_inst_found=1, if_inst_v=1, stallreq_if=1.
REQ-009 Redirect priority SHALL be clear over branch; the target is clear_pc or branch_target; pc SHALL be loaded with it and the current instruction dropped.
REQ-010 A redirect in REQ without inst_addr_ok SHALL stay in REQ with the new pc next cycle.
REQ-011 A redirect in REQ with inst_addr_ok, or in WAIT without inst_data_ok, SHALL go to DISCARD.
REQ-012 A redirect in WAIT with inst_data_ok, or in HOLD, SHALL go to REQ.
REQ-013 DISCARD SHALL ignore the first inst_data_ok, then go to REQ; a further redirect in DISCARD SHALL only update pc.
REQ-014 pc arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
REQ-015 At most one request SHALL be outstanding; inst_req SHALL be 0 outside REQ.

Reset
REQ-016 With rst=0 at a clk edge, the block SHALL set pc=RESET_PC, state=REQ, data=0, found_r=1, overriding any redirect.
REQ-017 Reset mid-transaction SHALL NOT discard the outstanding response; the memory side is reset by the same rst.

Configuration
REQ-018 With IF_ALIGN_CHECK_EN defined, a pc with pc[1:0]!=0 in REQ SHALL issue no request and go directly to HOLD with data=0, found_r=1, and if_inst_v=0 on delivery.
REQ-019 Without IF_ALIGN_CHECK_EN, pc[1:0] SHALL be ignored and if_inst_v SHALL always be 1.

Verification
REQ-020 Reset, then addr_ok at cycle 1 and data_ok=32'h24080001 at cycle 3 -> if2_pc=BFC00000 and if2_inst=24080001 at cycle 3, inst_addr=BFC00004 at cycle 4.
REQ-021 pause[1]=1 for 3 cycles around data_ok -> HOLD presents the same pc/inst; pc advances only after pause[1] falls.
REQ-022 branch=1 with target 80001000 in WAIT -> DISCARD, next data_ok dropped with bubble output, then inst_addr=80001000.
REQ-023 clear with clear_pc=BFC00380 and branch in the same cycle -> pc=BFC00380.
REQ-024 With IF_ALIGN_CHECK_EN, branch to 80000002 -> no inst_req, delivery has if2_pc=80000002 and if_inst_v=0; without the macro a request is issued.
REQ-025 tlb_hit=0 at addr_ok -> if_inst_found=0 on delivery; rst=0 in WAIT -> pc=BFC00000 next cycle.

Source files
------------

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch front end.
//
// Issues one instruction request at a time from the pc register. It delivers
// the returned word to the if_id stage, or buffers it while if_id is stalled.
// A redirect (clear or branch) reloads pc and drops the instruction in flight.
// If the request for that instruction has already been accepted, its response
// is swallowed in DISCARD.
//
// Optional feature (macro IF_ALIGN_CHECK_EN):
//   When defined, a misaligned pc (pc[1:0] != 0) issues no request. The fetch
//   delivers a dummy instruction with if_inst_v=0 so that later stages can
//   raise an address error.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   pause[5:0]          stall vector; pause[1] holds the if_id register
//   clear, clear_pc     exception/eret flush and its target
//   branch,
//   branch_target       branch resolved in ID and its target
//   tlb_hit             mapping hit for the current inst_addr
//   inst_req/addr       request channel to instruction memory
//   inst_addr_ok        request accepted
//   inst_data_ok/rdata  read response
//   if2_pc/if2_inst     pc and instruction delivered to if_id
//   if_inst_found       mapping hit for the delivered instruction
//   if_inst_v           address valid for the delivered instruction
//   stallreq_if         fetch has nothing to deliver this cycle
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  pause,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        tlb_hit,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if2_pc,
  output logic [31:0] if2_inst,
  output logic        if_inst_found,
  output logic        if_inst_v,
  output logic        stallreq_if
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] data_q, data_d;
  logic        found_q, found_d;

  logic        hold_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic        deliver;

  // Only pause[1] concerns this stage; the other bits belong to other stages.
  logic unused_pause;
  assign unused_pause = &{1'b0, pause[5:2], pause[0]};

  assign hold_id     = pause[1];
  assign redirect    = clear | branch;
  assign redirect_pc = clear ? clear_pc : branch_target;

`ifdef IF_ALIGN_CHECK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      found_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      found_q <= found_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    found_d = found_q;

    unique case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // An accepted request still returns a response that must be dropped.
          if (inst_req && inst_addr_ok) state_d = S_DISCARD;
        end else if (misaligned) begin
          data_d  = '0;
          found_d = 1'b1;
          state_d = S_HOLD;
        end else if (inst_addr_ok) begin
          found_d = tlb_hit;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = inst_data_ok ? S_REQ : S_DISCARD;
        end else if (inst_data_ok) begin
          data_d = inst_rdata;
          if (hold_id) begin
            state_d = S_HOLD;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!hold_id) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        if (redirect) pc_d = redirect_pc;
        if (inst_data_ok) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // A redirect in the same cycle kills whatever would have been delivered.
  assign deliver = !redirect &&
                   ((state_q == S_HOLD) || ((state_q == S_WAIT) && inst_data_ok));

  always_comb begin
    inst_req      = (state_q == S_REQ) && !misaligned;
    inst_addr     = pc_q;
    if2_pc        = '0;
    if2_inst      = '0;
    if_inst_found = 1'b1;
    if_inst_v     = 1'b1;
    stallreq_if   = 1'b1;
    if (deliver) begin
      if2_pc        = pc_q;
      if2_inst      = (state_q == S_HOLD) ? data_q : inst_rdata;
      if_inst_found = found_q;
      if_inst_v     = !misaligned;
      stallreq_if   = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pause;
  logic        clear;
  logic [31:0] clear_pc;
  logic        branch;
  logic [31:0] branch_target;
  logic        tlb_hit;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if2_pc;
  logic [31:0] if2_inst;
  logic        if_inst_found;
  logic        if_inst_v;
  logic        stallreq_if;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'hBFC00000)) dut (
    .clk           (clk),
    .rst           (rst),
    .pause         (pause),
    .clear         (clear),
    .clear_pc      (clear_pc),
    .branch        (branch),
    .branch_target (branch_target),
    .tlb_hit       (tlb_hit),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .if2_pc        (if2_pc),
    .if2_inst      (if2_inst),
    .if_inst_found (if_inst_found),
    .if_inst_v     (if_inst_v),
    .stallreq_if   (stallreq_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance to the next negedge and return pulse inputs to idle.
  task automatic next_cyc();
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    branch       = 1'b0;
    clear        = 1'b0;
    pause        = '0;
  endtask

  initial begin
    rst = 1'b0; pause = '0; clear = 1'b0; clear_pc = '0; branch = 1'b0;
    branch_target = '0; tlb_hit = 1'b1; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr",  inst_addr, 32'hBFC00000);
    chk("rst_req",   {31'd0, inst_req}, 32'd1);
    chk("rst_stall", {31'd0, stallreq_if}, 32'd1);
    chk("rst_pc_out", if2_pc, 32'h0);
    chk("rst_found", {31'd0, if_inst_found}, 32'd1);
    chk("rst_v",     {31'd0, if_inst_v}, 32'd1);
    rst = 1'b1;                                       // cycle 0

    // basic fetch: addr_ok at cycle 1, data_ok at cycle 3
    next_cyc(); inst_addr_ok = 1'b1;                  // cycle 1
    next_cyc(); #1;                                   // cycle 2
    chk("wait_req", {31'd0, inst_req}, 32'd0);
    chk("wait_stall", {31'd0, stallreq_if}, 32'd1);
    next_cyc(); inst_data_ok = 1'b1; inst_rdata = 32'h24080001; #1;  // cycle 3
    chk("dlv_pc",    if2_pc, 32'hBFC00000);
    chk("dlv_inst",  if2_inst, 32'h24080001);
    chk("dlv_stall", {31'd0, stallreq_if}, 32'd0);
    next_cyc(); #1;                                   // cycle 4
    chk("next_addr", inst_addr, 32'hBFC00004);
    chk("next_req",  {31'd0, inst_req}, 32'd1);

    // pause[1] held for three cycles around data_ok
    inst_addr_ok = 1'b1;
    next_cyc(); pause = 6'b000010; inst_data_ok = 1'b1; inst_rdata = 32'h11111111; #1;
    chk("p_dlv_pc", if2_pc, 32'hBFC00004);
    next_cyc(); pause = 6'b000010; inst_rdata = 32'h0; #1;
    chk("hold_pc",   if2_pc, 32'hBFC00004);
    chk("hold_inst", if2_inst, 32'h11111111);
    chk("hold_req",  {31'd0, inst_req}, 32'd0);
    next_cyc(); pause = 6'b000010; #1;
    chk("hold_addr", inst_addr, 32'hBFC00004);
    chk("hold2_inst", if2_inst, 32'h11111111);
    next_cyc(); #1;
    chk("rel_stall", {31'd0, stallreq_if}, 32'd0);
    chk("rel_inst",  if2_inst, 32'h11111111);
    next_cyc(); #1;
    chk("rel_addr",  inst_addr, 32'hBFC00008);

    // branch while waiting -> stale response dropped
    inst_addr_ok = 1'b1;
    next_cyc(); branch = 1'b1; branch_target = 32'h80001000; #1;
    chk("br_stall", {31'd0, stallreq_if}, 32'd1);
    next_cyc(); inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF; #1;
    chk("disc_inst",  if2_inst, 32'h0);
    chk("disc_stall", {31'd0, stallreq_if}, 32'd1);
    chk("disc_req",   {31'd0, inst_req}, 32'd0);
    next_cyc(); #1;
    chk("br_addr", inst_addr, 32'h80001000);
    chk("br_req",  {31'd0, inst_req}, 32'd1);

    // clear beats branch; redirect in REQ without addr_ok stays in REQ
    clear = 1'b1; clear_pc = 32'hBFC00380; branch = 1'b1; branch_target = 32'h80002000;
    next_cyc(); #1;
    chk("clr_addr", inst_addr, 32'hBFC00380);
    chk("clr_req",  {31'd0, inst_req}, 32'd1);

    // tlb miss recorded at addr_ok
    inst_addr_ok = 1'b1; tlb_hit = 1'b0;
    next_cyc(); tlb_hit = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hAAAA5555; #1;
    chk("miss_found", {31'd0, if_inst_found}, 32'd0);
    chk("miss_pc",    if2_pc, 32'hBFC00380);
    next_cyc(); #1;
    chk("miss_next", inst_addr, 32'hBFC00384);

    // redirect in REQ together with addr_ok -> DISCARD
    inst_addr_ok = 1'b1; branch = 1'b1; branch_target = 32'h80003000;
    next_cyc(); #1;
    chk("rq_disc_req", {31'd0, inst_req}, 32'd0);
    inst_data_ok = 1'b1; inst_rdata = 32'h12345678; #1;
    chk("rq_disc_stall", {31'd0, stallreq_if}, 32'd1);
    next_cyc(); #1;
    chk("rq_disc_addr", inst_addr, 32'h80003000);

    // reset while waiting
    inst_addr_ok = 1'b1;
    next_cyc(); rst = 1'b0; branch = 1'b1; branch_target = 32'h80004000;
    next_cyc(); rst = 1'b1; #1;
    chk("mid_rst_addr", inst_addr, 32'hBFC00000);
    chk("mid_rst_req",  {31'd0, inst_req}, 32'd1);

    // pc wraps modulo 2^32
    branch = 1'b1; branch_target = 32'hFFFFFFFC;
    next_cyc(); #1;
    chk("wrap_addr0", inst_addr, 32'hFFFFFFFC);
    inst_addr_ok = 1'b1;
    next_cyc(); inst_data_ok = 1'b1; inst_rdata = 32'h00000000; #1;
    chk("wrap_dlv_pc", if2_pc, 32'hFFFFFFFC);
    next_cyc(); #1;
    chk("wrap_addr", inst_addr, 32'h0);

    // misaligned target
    branch = 1'b1; branch_target = 32'h80000002;
    next_cyc(); #1;
`ifdef IF_ALIGN_CHECK_EN
    chk("al_req", {31'd0, inst_req}, 32'd0);
    next_cyc(); pause = 6'b000010; #1;
    chk("al_pc",   if2_pc, 32'h80000002);
    chk("al_v",    {31'd0, if_inst_v}, 32'd0);
    chk("al_inst", if2_inst, 32'h0);
`else
    chk("al_req",  {31'd0, inst_req}, 32'd1);
    chk("al_addr", inst_addr, 32'h80000002);
    inst_addr_ok = 1'b1;
    next_cyc(); inst_data_ok = 1'b1; inst_rdata = 32'h0000000F; #1;
    chk("al_v",    {31'd0, if_inst_v}, 32'd1);
    chk("al_pc",   if2_pc, 32'h80000002);
`endif

    next_cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
